// File: rtl/riscv_dp_pkg.sv
// Shared widths and constants for the RISC-V datapath operand-read slice.
package riscv_dp_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int CTRL_WIDTH = 16;

  // x0 is hard-wired to zero; it is never bypassed or refreshed.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/riscv_dp_opsel.sv
// Operand select for one source: x0 -> 0, else same-cycle writeback, else register file.
module riscv_dp_opsel
  import riscv_dp_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] rf_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data
);

  // NOTE: a full if/else chain that assigns data on every path keeps this purely combinational (no latch).
  always_comb begin
    if (idx == AW'(ZERO_REG)) begin
      data = '0;
    end else if (wb_en && (wb_addr == idx)) begin
      data = wb_data;
    end else begin
      data = rf_data;
    end
  end

endmodule

// File: rtl/riscv_dp_opread.sv
// Operand-read stage: register-file read, WB bypass, load-use hazard and a valid/ready output register.
module riscv_dp_opread
  import riscv_dp_pkg::*;
#(
  parameter int MP_DATA_WIDTH = DATA_WIDTH,
  parameter int MP_ADDR_WIDTH = ADDR_WIDTH,
  parameter int MP_CTRL_WIDTH = CTRL_WIDTH
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     ivalid,
  output logic                     oready,
  input  logic [MP_ADDR_WIDTH-1:0] irs1,
  input  logic [MP_ADDR_WIDTH-1:0] irs2,
  input  logic [MP_ADDR_WIDTH-1:0] ird,
  input  logic                     iuse_rs1,
  input  logic                     iuse_rs2,
  input  logic [MP_DATA_WIDTH-1:0] iimm,
  input  logic [MP_DATA_WIDTH-1:0] ipc,
  input  logic [MP_CTRL_WIDTH-1:0] ictrl,
  output logic [MP_ADDR_WIDTH-1:0] oaddr1,
  output logic [MP_ADDR_WIDTH-1:0] oaddr2,
  input  logic [MP_DATA_WIDTH-1:0] irf_data1,
  input  logic [MP_DATA_WIDTH-1:0] irf_data2,
  input  logic                     iwb_en,
  input  logic [MP_ADDR_WIDTH-1:0] iwb_addr,
  input  logic [MP_DATA_WIDTH-1:0] iwb_data,
  input  logic                     iex_ld,
  input  logic [MP_ADDR_WIDTH-1:0] iex_rd,
  input  logic                     iflush,
  output logic                     ovalid,
  input  logic                     iready,
  output logic [MP_ADDR_WIDTH-1:0] ors1,
  output logic [MP_ADDR_WIDTH-1:0] ors2,
  output logic [MP_ADDR_WIDTH-1:0] ord,
  output logic [MP_DATA_WIDTH-1:0] ors1_data,
  output logic [MP_DATA_WIDTH-1:0] ors2_data,
  output logic [MP_DATA_WIDTH-1:0] oimm,
  output logic [MP_DATA_WIDTH-1:0] opc,
  output logic [MP_CTRL_WIDTH-1:0] octrl
);

  localparam logic [MP_ADDR_WIDTH-1:0] XZERO = MP_ADDR_WIDTH'(ZERO_REG);

  logic                     hazard;
  logic                     accept;
  logic                     pop;
  logic [MP_DATA_WIDTH-1:0] sel1;
  logic [MP_DATA_WIDTH-1:0] sel2;

  assign oaddr1 = irs1;
  assign oaddr2 = irs2;

  assign hazard = iex_ld && (iex_rd != XZERO) &&
                  ((iuse_rs1 && (irs1 == iex_rd)) || (iuse_rs2 && (irs2 == iex_rd)));
  assign oready = (!ovalid || iready) && !hazard;
  assign accept = ivalid && oready;
  assign pop    = ovalid && iready;

  riscv_dp_opsel #(.DW(MP_DATA_WIDTH), .AW(MP_ADDR_WIDTH)) u_sel1 (
    .idx     (irs1),
    .rf_data (irf_data1),
    .wb_en   (iwb_en),
    .wb_addr (iwb_addr),
    .wb_data (iwb_data),
    .data    (sel1)
  );

  riscv_dp_opsel #(.DW(MP_DATA_WIDTH), .AW(MP_ADDR_WIDTH)) u_sel2 (
    .idx     (irs2),
    .rf_data (irf_data2),
    .wb_en   (iwb_en),
    .wb_addr (iwb_addr),
    .wb_data (iwb_data),
    .data    (sel2)
  );

  // NOTE: the data fields are reset too, so EX never samples X from an empty stage.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ovalid    <= 1'b0;
      ors1      <= '0;
      ors2      <= '0;
      ord       <= '0;
      ors1_data <= '0;
      ors2_data <= '0;
      oimm      <= '0;
      opc       <= '0;
      octrl     <= '0;
    end else if (iflush) begin
      ovalid <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments make every field update from the same pre-edge values.
      ovalid    <= 1'b1;
      ors1      <= irs1;
      ors2      <= irs2;
      ord       <= ird;
      ors1_data <= sel1;
      ors2_data <= sel2;
      oimm      <= iimm;
      opc       <= ipc;
      octrl     <= ictrl;
    end else if (pop) begin
      ovalid <= 1'b0;
    end else if (ovalid) begin
      // Held bundle: pick up writes that land while EX is stalled.
      if (iwb_en && (iwb_addr != XZERO) && (iwb_addr == ors1)) ors1_data <= iwb_data;
      if (iwb_en && (iwb_addr != XZERO) && (iwb_addr == ors2)) ors2_data <= iwb_data;
    end
  end

endmodule

// File: tb/tb_riscv_dp_opread.sv
// Directed self-checking bench for riscv_dp_opread with hand-computed expectations.
module tb_riscv_dp_opread;

  logic        iclk = 1'b0;
  logic        irst;
  logic        ivalid;
  logic        oready;
  logic [4:0]  irs1, irs2, ird;
  logic        iuse_rs1, iuse_rs2;
  logic [31:0] iimm, ipc;
  logic [15:0] ictrl;
  logic [4:0]  oaddr1, oaddr2;
  logic [31:0] irf_data1, irf_data2;
  logic        iwb_en;
  logic [4:0]  iwb_addr;
  logic [31:0] iwb_data;
  logic        iex_ld;
  logic [4:0]  iex_rd;
  logic        iflush;
  logic        ovalid;
  logic        iready;
  logic [4:0]  ors1, ors2, ord;
  logic [31:0] ors1_data, ors2_data, oimm, opc;
  logic [15:0] octrl;

  int checks = 0;
  int errors = 0;

  always #5 iclk = ~iclk;

  riscv_dp_opread dut (
    .iclk(iclk), .irst(irst), .ivalid(ivalid), .oready(oready),
    .irs1(irs1), .irs2(irs2), .ird(ird), .iuse_rs1(iuse_rs1), .iuse_rs2(iuse_rs2),
    .iimm(iimm), .ipc(ipc), .ictrl(ictrl), .oaddr1(oaddr1), .oaddr2(oaddr2),
    .irf_data1(irf_data1), .irf_data2(irf_data2),
    .iwb_en(iwb_en), .iwb_addr(iwb_addr), .iwb_data(iwb_data),
    .iex_ld(iex_ld), .iex_rd(iex_rd), .iflush(iflush),
    .ovalid(ovalid), .iready(iready),
    .ors1(ors1), .ors2(ors2), .ord(ord), .ors1_data(ors1_data), .ors2_data(ors2_data),
    .oimm(oimm), .opc(opc), .octrl(octrl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc);
    ivalid    = 1'b1;
    irs1      = rs1;
    irs2      = rs2;
    ird       = rd;
    iuse_rs1  = 1'b1;
    iuse_rs2  = 1'b1;
    irf_data1 = d1;
    irf_data2 = d2;
    ipc       = pc;
    iimm      = pc + 32'h1000;
    ictrl     = pc[15:0] ^ 16'hA5A5;
  endtask

  initial begin
    irst = 1'b1; ivalid = 1'b0; irs1 = '0; irs2 = '0; ird = '0;
    iuse_rs1 = 1'b0; iuse_rs2 = 1'b0; iimm = '0; ipc = '0; ictrl = '0;
    irf_data1 = '0; irf_data2 = '0; iwb_en = 1'b0; iwb_addr = '0; iwb_data = '0;
    iex_ld = 1'b0; iex_rd = '0; iflush = 1'b0; iready = 1'b1;
    #3;
    check("rst_ovalid", 32'(ovalid), 0);
    check("rst_oready", 32'(oready), 1);
    check("rst_ors1_data", ors1_data, 0);
    check("rst_opc", opc, 0);
    check("rst_octrl", 32'(octrl), 0);
    step();
    irst = 1'b0;
    step();

    // Single instruction, plain register-file read.
    drive(5'd3, 5'd4, 5'd10, 32'h11, 32'h22, 32'h100);
    #1;
    check("oaddr1", 32'(oaddr1), 3);
    check("oaddr2", 32'(oaddr2), 4);
    check("single_oready", 32'(oready), 1);
    step();
    ivalid = 1'b0;
    check("single_ovalid", 32'(ovalid), 1);
    check("single_rs1_data", ors1_data, 32'h11);
    check("single_rs2_data", ors2_data, 32'h22);
    check("single_ors1", 32'(ors1), 3);
    check("single_ord", 32'(ord), 10);
    check("single_oimm", oimm, 32'h1100);
    check("single_opc", opc, 32'h100);
    check("single_octrl", 32'(octrl), 32'hA4A5);
    step();
    check("single_pop", 32'(ovalid), 0);

    // Same-cycle writeback bypass.
    drive(5'd5, 5'd6, 5'd1, 32'hAA, 32'h66, 32'h104);
    iwb_en = 1'b1; iwb_addr = 5'd5; iwb_data = 32'hBB;
    step();
    check("bypass_rs1_data", ors1_data, 32'hBB);
    check("bypass_rs2_data", ors2_data, 32'h66);
    // x0 is never bypassed even when WB targets it.
    drive(5'd0, 5'd6, 5'd1, 32'h77, 32'h66, 32'h108);
    iwb_addr = 5'd0; iwb_data = 32'hCC;
    step();
    iwb_en = 1'b0; ivalid = 1'b0;
    check("x0_valid", 32'(ovalid), 1);
    check("x0_rs1_data", ors1_data, 0);

    // Load-use hazard: one bubble.
    iex_ld = 1'b1; iex_rd = 5'd7;
    drive(5'd1, 5'd7, 5'd2, 32'h01, 32'h07, 32'h10C);
    #1;
    check("ldu_oready", 32'(oready), 0);
    step();
    check("ldu_bubble", 32'(ovalid), 0);
    iex_ld = 1'b0;
    #1;
    check("ldu_release_oready", 32'(oready), 1);
    step();
    ivalid = 1'b0;
    check("ldu_issue_valid", 32'(ovalid), 1);
    check("ldu_issue_pc", opc, 32'h10C);
    check("ldu_issue_rs2", ors2_data, 32'h07);
    // No hazard for rd=0 or when the matching source is unused.
    iex_ld = 1'b1; iex_rd = 5'd0; irs1 = 5'd0; iuse_rs1 = 1'b1;
    #1;
    check("ldu_rd0_oready", 32'(oready), 1);
    iex_rd = 5'd7; irs2 = 5'd7; iuse_rs2 = 1'b0;
    #1;
    check("ldu_unused_oready", 32'(oready), 1);
    iex_ld = 1'b0;
    step();

    // Back-pressure with writeback refresh of the held operand.
    drive(5'd9, 5'd2, 5'd3, 32'h09, 32'h20, 32'h200);
    step();
    iready = 1'b0;
    drive(5'd1, 5'd2, 5'd4, 32'h31, 32'h32, 32'h204);
    #1;
    check("bp_oready", 32'(oready), 0);
    step();
    iwb_en = 1'b1; iwb_addr = 5'd9; iwb_data = 32'h55;
    step();
    iwb_en = 1'b0;
    step();
    check("bp_hold_valid", 32'(ovalid), 1);
    check("bp_refresh_rs1", ors1_data, 32'h55);
    check("bp_hold_rs2", ors2_data, 32'h20);
    check("bp_hold_pc", opc, 32'h200);
    iready = 1'b1;
    #1;
    check("bp_release_oready", 32'(oready), 1);
    step();
    ivalid = 1'b0;
    check("bp_next_valid", 32'(ovalid), 1);
    check("bp_next_pc", opc, 32'h204);
    check("bp_next_rs1", ors1_data, 32'h31);
    step();
    check("bp_drain", 32'(ovalid), 0);

    // Flush beats simultaneous accept and pop.
    drive(5'd1, 5'd2, 5'd5, 32'h41, 32'h42, 32'h300);
    step();
    drive(5'd1, 5'd2, 5'd6, 32'h51, 32'h52, 32'h304);
    iflush = 1'b1;
    step();
    iflush = 1'b0; ivalid = 1'b0;
    check("flush_valid", 32'(ovalid), 0);
    step();
    check("flush_no_emit", 32'(ovalid), 0);

    // Asynchronous reset in the middle of a cycle.
    drive(5'd3, 5'd4, 5'd7, 32'h61, 32'h62, 32'h400);
    step();
    check("ar_pre_valid", 32'(ovalid), 1);
    drive(5'd3, 5'd4, 5'd8, 32'h71, 32'h72, 32'h404);
    #2;
    irst = 1'b1;
    #1;
    check("ar_valid", 32'(ovalid), 0);
    check("ar_rs1_data", ors1_data, 0);
    check("ar_opc", opc, 0);
    check("ar_ord", 32'(ord), 0);
    step();
    ivalid = 1'b0;
    irst = 1'b0;
    step();
    check("ar_no_emit", 32'(ovalid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
